// File: rtl/jtag_scan_master_if.sv
// Command/response bundle for jtag_scan_master.
// master: host issuing commands; slave: the scan engine.
interface jtag_scan_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG scan initiator: turns TLR / IR / DR / idle-run commands into TCK/TMS/TDI.
// Ports: clk, rst_n, bus (cmd/rsp slave), TCK, TMS, TDI out, TDO in.
module jtag_scan_master #(
  parameter int TCK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  jtag_scan_master_if.slave bus,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SHIFT, S_POST, S_RUN, S_DONE
  } state_t;

  localparam logic [1:0] OP_TLR = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_RUN = 2'b11;

  localparam logic [8:0] HALF = 9'(TCK_DIV);
  localparam logic [8:0] LAST = 9'(2 * TCK_DIV - 1);

  state_t      state;
  logic [8:0]  div;
  logic [1:0]  op;
  logic [4:0]  n;
  logic [15:0] data;
  logic [2:0]  hdr_n;
  logic [5:0]  hdr_pat;
  logic [15:0] cnt;
  logic [15:0] cap;
  logic        samp;
  logic [3:0]  samp_idx;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_q;
  logic        fin;

  wire period_start = (div == 9'd0);
  wire rise         = (div == HALF);

  assign bus.cmd_ready = !busy_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q;

  // Sequence exhausted: the period that would start now is not issued.
  always_comb begin
    fin = 1'b0;
    unique case (state)
      S_HDR:   fin = (cnt == 16'(hdr_n));
      S_POST:  fin = (cnt == 16'd2);
      S_RUN:   fin = (cnt == data);
      default: fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      div         <= '0;
      op          <= '0;
      n           <= '0;
      data        <= '0;
      hdr_n       <= '0;
      hdr_pat     <= '0;
      cnt         <= '0;
      cap         <= '0;
      samp        <= 1'b0;
      samp_idx    <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      TCK         <= 1'b0;
      TMS         <= 1'b1;
      TDI         <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state != S_IDLE && state != S_DONE)
        div <= (div == LAST) ? 9'd0 : div + 9'd1;
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid && !busy_q) begin
            op     <= bus.cmd_op;
            n      <= (bus.cmd_len == 4'd0) ? 5'd16 : {1'b0, bus.cmd_len};
            data   <= bus.cmd_data;
            cnt    <= '0;
            div    <= '0;
            cap    <= '0;
            samp   <= 1'b0;
            busy_q <= 1'b1;
            state  <= (bus.cmd_op == OP_RUN) ? S_RUN : S_HDR;
            // Header TMS bits, bit 0 first.
            if (bus.cmd_op == OP_TLR) begin
              hdr_n   <= 3'd6;
              hdr_pat <= 6'b011111;
            end else if (bus.cmd_op == OP_IR) begin
              hdr_n   <= 3'd4;
              hdr_pat <= 6'b000011;
            end else begin
              hdr_n   <= 3'd3;
              hdr_pat <= 6'b000001;
            end
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          // TDO is taken on the same edge that raises TCK.
          if (rise) begin
            TCK <= 1'b1;
            if (samp)
              cap[samp_idx] <= TDO;
          end
          if (period_start) begin
            TCK  <= 1'b0;
            TDI  <= 1'b0;
            samp <= 1'b0;
            if (fin) begin
              state       <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_q       <= cap;
            end else begin
              unique case (state)
                S_HDR: begin
                  TMS <= hdr_pat[cnt[2:0]];
                  if (op != OP_TLR && cnt == 16'(hdr_n - 3'd1)) begin
                    state <= S_SHIFT;
                    cnt   <= '0;
                  end else begin
                    cnt <= cnt + 16'd1;
                  end
                end
                S_SHIFT: begin
                  TMS      <= (cnt[4:0] == n - 5'd1);
                  TDI      <= data[cnt[3:0]];
                  samp     <= 1'b1;
                  samp_idx <= cnt[3:0];
                  if (cnt[4:0] == n - 5'd1) begin
                    state <= S_POST;
                    cnt   <= '0;
                  end else begin
                    cnt <= cnt + 16'd1;
                  end
                end
                S_POST: begin
                  TMS <= (cnt == 16'd0);
                  cnt <= cnt + 16'd1;
                end
                S_RUN: begin
                  TMS <= 1'b0;
                  cnt <= cnt + 16'd1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Randomized scoreboard bench for jtag_scan_master against a 1149.1 TAP model.
// Driver queues expected responses; a monitor checks each rsp_valid.
module tb_jtag_scan_master;

  localparam int D = 2;
  localparam logic [1:0] OP_TLR = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_DR  = 2'b10;
  localparam logic [1:0] OP_RUN = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic TCK, TMS, TDI, TDO;

  jtag_scan_master_if bus();

  jtag_scan_master #(.TCK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- TAP model ----------------
  typedef enum int {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR,
    T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR
  } tap_t;

  tap_t        ts = T_TLR;
  logic [3:0]  ir = 4'h1;
  logic [3:0]  ir_sr = 4'h0;
  logic [15:0] dr_val = 16'h0;
  logic [15:0] dr_sr = 16'h0;
  int          dr_len = 16;
  logic        tdo_r = 1'b0;
  assign TDO = tdo_r;

  function automatic tap_t nxt(tap_t s, logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PDR;
      T_PDR:   return m ? T_EX2DR : T_PDR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PIR;
      T_PIR:   return m ? T_EX2IR : T_PIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      T_UPIR:  return m ? T_SELDR : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  function automatic logic [15:0] shin(logic [15:0] s, logic b, int len);
    logic [15:0] r;
    r = s >> 1;
    r[len-1] = b;
    return r;
  endfunction

  always @(posedge TCK) begin
    case (ts)
      T_CAPDR: dr_sr <= dr_val;
      T_SHDR:  dr_sr <= shin(dr_sr, TDI, dr_len);
      T_CAPIR: ir_sr <= 4'b0101;
      T_SHIR:  ir_sr <= {TDI, ir_sr[3:1]};
      default: ;
    endcase
    ts <= nxt(ts, TMS);
  end

  always @(negedge TCK) begin
    tdo_r <= (ts == T_SHDR) ? dr_sr[0] :
             (ts == T_SHIR) ? ir_sr[0] : 1'b0;
    if (ts == T_UPDR) dr_val <= dr_sr;
    if (ts == T_UPIR) ir <= ir_sr;
    if (ts == T_TLR)  ir <= 4'h1;
  end

  // ---------------- reference + scoreboard ----------------
  typedef struct {
    logic [15:0] rsp;
    int          n;
    logic [63:0] tms;
    logic [63:0] tdi;
  } exp_t;

  exp_t q[$];
  logic [15:0] exp_dr = 16'h0;
  logic [3:0]  exp_ir = 4'h1;

  function automatic logic [15:0] mask(int n);
    return (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
  endfunction

  task automatic send(logic [1:0] op, logic [3:0] len, logic [15:0] d);
    int t = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_len   = 4'($urandom);
    bus.cmd_data  = 16'($urandom);
  endtask

  // Build the expected TCK/TMS/TDI stream and response from the command rules.
  task automatic issue(logic [1:0] op, int n, logic [15:0] d);
    exp_t e;
    int k = 0;
    e.tms = '0;
    e.tdi = '0;
    e.rsp = '0;
    case (op)
      OP_TLR: begin
        e.tms = 64'b011111;
        k = 6;
        exp_ir = 4'h1;
      end
      OP_IR, OP_DR: begin
        if (op == OP_IR) begin
          e.tms[1:0] = 2'b11;
          k = 4;
        end else begin
          e.tms[0] = 1'b1;
          k = 3;
        end
        for (int i = 0; i < n; i++) begin
          e.tdi[k] = d[i];
          e.tms[k] = (i == n - 1);
          k++;
        end
        e.tms[k] = 1'b1;
        k += 2;
        if (op == OP_IR) begin
          e.rsp = 16'h0005;
          exp_ir = d[3:0];
        end else begin
          e.rsp = exp_dr & mask(n);
          exp_dr = d & mask(n);
        end
      end
      default: k = int'(d);
    endcase
    e.n = k;
    q.push_back(e);
    send(op, (op == OP_RUN) ? 4'($urandom) : 4'(n), d);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || bus.busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        ready_prev = 1'b1;
    logic        tck_prev = 1'b0;
    logic        inflight = 1'b0;
    logic        chk_after = 1'b0;
    int          cyc = 0;
    int          start = 0;
    int          nt = 0;
    logic [63:0] tms_seen = '0;
    logic [63:0] tdi_seen = '0;
    exp_t        e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        ready_prev = 1'b1;
        tck_prev = 1'b0;
        inflight = 1'b0;
        chk_after = 1'b0;
        nt = 0;
      end else begin
        if (chk_after) begin
          check("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
          check("ready_back", 64'(bus.cmd_ready), 64'd1);
          chk_after = 1'b0;
        end
        if (bus.cmd_valid && ready_prev) begin
          check("overlap", 64'(inflight), 64'd0);
          inflight = 1'b1;
          start = cyc;
          nt = 0;
          tms_seen = '0;
          tdi_seen = '0;
        end
        if (TCK && !tck_prev) begin
          if (nt < 64) begin
            tms_seen[nt] = TMS;
            tdi_seen[nt] = TDI;
          end
          nt++;
        end
        tck_prev = TCK;
        if (bus.rsp_valid) begin
          if (q.size() == 0) begin
            check("stray_rsp", 64'(q.size()), 64'd1);
          end else begin
            e = q.pop_front();
            check("rsp_data", 64'(bus.rsp_data), 64'(e.rsp));
            check("tck_count", 64'(nt), 64'(e.n));
            check("tms_seq", tms_seen, e.tms);
            check("tdi_seq", tdi_seen, e.tdi);
            check("latency", 64'(cyc - start), 64'(2 * D * e.n + 1));
            check("busy_at_rsp", 64'(bus.busy), 64'd1);
          end
          inflight = 1'b0;
          chk_after = 1'b1;
        end
        ready_prev = bus.cmd_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int n;
    logic [15:0] d;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(TCK), 64'd0);
    check("rst_tms", 64'(TMS), 64'd1);
    check("rst_tdi", 64'(TDI), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    rst_n = 1'b1;

    issue(OP_TLR, 0, 16'h0);
    wait_idle();
    check("tap_idle_tlr", 64'(ts), 64'(T_RTI));

    issue(OP_IR, 4, 16'h0008);
    wait_idle();
    check("ir_value", 64'(ir), 64'h8);
    check("tap_idle_ir", 64'(ts), 64'(T_RTI));

    dr_len = 10;
    dr_val = 16'h02C3;
    exp_dr = 16'h02C3;
    issue(OP_DR, 10, 16'h03A5);
    wait_idle();
    check("dr10_value", 64'(dr_val), 64'h3A5);

    dr_len = 16;
    dr_val = 16'hBEEF;
    exp_dr = 16'hBEEF;
    issue(OP_DR, 16, 16'h1234);
    wait_idle();
    check("dr16_value", 64'(dr_val), 64'h1234);

    // Second command is held off while the first runs.
    issue(OP_RUN, 0, 16'd3);
    issue(OP_RUN, 0, 16'd0);
    wait_idle();
    check("tap_idle_run", 64'(ts), 64'(T_RTI));

    // Abort a DR scan while TCK is high.
    dr_len = 10;
    dr_val = 16'h0155;
    exp_dr = 16'h0155;
    send(OP_DR, 4'd10, 16'h00FF);
    t = 0;
    while (!TCK && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort_tck_seen", 64'(TCK), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_tck", 64'(TCK), 64'd0);
    check("abort_tms", 64'(TMS), 64'd1);
    check("abort_tdi", 64'(TDI), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    issue(OP_TLR, 0, 16'h0);
    wait_idle();
    check("dr_kept", 64'(dr_val), 64'(exp_dr));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        wait_idle();
        check("rand_ir", 64'(ir), 64'(exp_ir));
        check("rand_dr", 64'(dr_val), 64'(exp_dr));
        if ($urandom_range(1, 0) == 1) begin
          dr_len = $urandom_range(16, 1);
          dr_val = 16'($urandom) & mask(dr_len);
          exp_dr = dr_val;
        end
      end
      d = 16'($urandom);
      case ($urandom_range(3, 0))
        0: issue(OP_TLR, 0, d);
        1: issue(OP_IR, 4, d);
        2: issue(OP_DR, dr_len, d);
        default: begin
          n = $urandom_range(12, 0);
          issue(OP_RUN, 0, 16'(n));
        end
      endcase
    end
    wait_idle();
    check("end_ir", 64'(ir), 64'(exp_ir));
    check("end_dr", 64'(dr_val), 64'(exp_dr));
    check("end_tap", 64'(ts), 64'(T_RTI));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
